// File: rtl/accumulate_pkg.sv
// Shared types and sizing for the accumulate kernel driver.
package accumulate_pkg;
  localparam int N  = 1000;
  localparam int AW = 10;
  localparam int DW = 64;

  typedef enum logic [1:0] {LOAD, KICK, RUN, DRAIN} drv_state_t;

  typedef logic signed [DW-1:0] word_t;

  function automatic logic at_last(input logic [AW-1:0] ptr);
    return ptr == AW'(N - 1);
  endfunction
endpackage

// File: rtl/accumulate_driver_fifo.sv
// Two-entry valid/ready FIFO carrying a drained word plus its last tag.
// The writer guarantees it never pushes into a full FIFO.
module drv_skid_fifo
  import accumulate_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_last_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic [DW-1:0] pop_data_o,
  output logic          pop_last_o,
  output logic [1:0]    count_o
);
  word_t      data_q [2];
  logic [1:0] last_q;
  logic       wr_q;
  logic       rd_q;
  logic [1:0] count_q;
  logic       pop;

  assign pop = (count_q != 2'd0) && pop_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
      last_q  <= 2'b00;
    end else begin
      if (push_i) begin
        last_q[wr_q] <= push_last_i;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop};
    end
  end

  // Payload needs no reset; the count gates its visibility.
  always_ff @(posedge clk) begin
    if (push_i) begin
      data_q[wr_q] <= push_data_i;
    end
  end

  assign pop_valid_o = (count_q != 2'd0);
  assign pop_data_o  = data_q[rd_q];
  assign pop_last_o  = last_q[rd_q];
  assign count_o     = count_q;
endmodule

// File: rtl/accumulate_driver.sv
// Host-side driver for the accumulate kernel: loads the array, runs the kernel,
// then streams the updated array back out through a 2-entry skid FIFO.
module accumulate_driver
  import accumulate_pkg::*;
#(
  parameter int TIMEOUT = 65536
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cfg_i,
  input  logic [DW-1:0] cfg_acc,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          k_r_enable,
  output logic [AW-1:0] k_init_i,
  output logic [DW-1:0] k_init_acc,
  input  logic          k_w_enable,
  input  logic          k_result,
  output logic          k_controlArr,
  output logic          k_arr_wen,
  output logic [AW-1:0] k_arr_addr,
  output logic [DW-1:0] k_arr_wdata,
  input  logic [DW-1:0] k_arr_rdata,
  output logic          busy,
  output logic          result_valid,
  output logic          result,
  output logic          err_timeout
);
  localparam int CW = $clog2(TIMEOUT);

  drv_state_t    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_done_q, rd_done_d;
  logic          inflight_q, inflight_d;
  logic          infl_last_q, infl_last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] init_i_q, init_i_d;
  word_t         init_acc_q, init_acc_d;
  logic          res_valid_q, res_valid_d;
  logic          res_q, res_d;
  logic          err_q, err_d;

  logic          fifo_valid;
  logic          fifo_last;
  logic [DW-1:0] fifo_data;
  logic [1:0]    fifo_count;
  logic          pop;
  logic          issue;
  logic [2:0]    occ;

  assign pop = fifo_valid && out_ready && (state_q == DRAIN);
  // Occupancy the FIFO will have once the outstanding read lands.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_done_d   = rd_done_q;
    inflight_d  = 1'b0;
    infl_last_d = 1'b0;
    cnt_d       = cnt_q;
    init_i_d    = init_i_q;
    init_acc_d  = init_acc_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    err_d       = err_q;
    issue       = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (at_last(wr_ptr_q)) begin
            wr_ptr_d   = '0;
            init_i_d   = cfg_i;
            init_acc_d = cfg_acc;
            state_d    = KICK;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      KICK: begin
        res_valid_d = 1'b0;
        cnt_d       = '0;
        rd_ptr_d    = '0;
        rd_done_d   = 1'b0;
        state_d     = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (k_w_enable) begin
          res_d       = k_result;
          res_valid_d = 1'b1;
          state_d     = DRAIN;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        issue       = !rd_done_q && (occ < 3'd2);
        inflight_d  = issue;
        infl_last_d = issue && at_last(rd_ptr_q);
        if (issue) begin
          if (at_last(rd_ptr_q)) begin
            rd_done_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
        if (pop && fifo_last) begin
          wr_ptr_d = '0;
          state_d  = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_done_q   <= 1'b0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= '0;
      init_i_q    <= '0;
      init_acc_q  <= '0;
      res_valid_q <= 1'b0;
      res_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_done_q   <= rd_done_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      init_i_q    <= init_i_d;
      init_acc_q  <= init_acc_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      err_q       <= err_d;
    end
  end

  drv_skid_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (k_arr_rdata),
    .push_last_i (infl_last_q),
    .pop_valid_o (fifo_valid),
    .pop_ready_i (pop),
    .pop_data_o  (fifo_data),
    .pop_last_o  (fifo_last),
    .count_o     (fifo_count)
  );

  // The kernel only touches the array in KICK/RUN; every other state fences it off.
  assign k_controlArr = (state_q == LOAD) || (state_q == DRAIN);
  assign k_r_enable   = (state_q == KICK);
  assign k_init_i     = init_i_q;
  assign k_init_acc   = init_acc_q;
  assign k_arr_wen    = (state_q == LOAD) && in_valid;
  assign k_arr_addr   = (state_q == DRAIN) ? rd_ptr_q : wr_ptr_q;
  assign k_arr_wdata  = in_data;

  assign in_ready     = (state_q == LOAD);
  assign out_valid    = fifo_valid && (state_q == DRAIN);
  assign out_data     = fifo_data;
  assign out_last     = fifo_last;
  assign busy         = (state_q != LOAD);
  assign result_valid = res_valid_q;
  assign result       = res_q;
  assign err_timeout  = err_q;
endmodule
